// File: rtl/motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : motion_sequencer
// Brief    : Queued motion-command sequencer with a 4-deep command FIFO and
//            arbitration of the motor controller register port between CPU
//            pass-through accesses and sequencer writes.
// Options  : MOTION_SEQ_IRQ_EN adds a one-cycle 'irq' pulse on stop->idle.
// Revision : 1.0 - initial release
// ============================================================================
module motion_sequencer #(
    parameter logic [7:0]  SEQ_ADDRESS = 8'h10,
    parameter logic [7:0]  MC_ADDRESS  = 8'h00,
    parameter int unsigned CPU_FREQ    = 16000000,
    parameter int unsigned TICK_HZ     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    output logic [7:0] mc_address,
    output logic [7:0] mc_din,
    output logic       mc_w_en,
    output logic       mc_r_en
`ifdef MOTION_SEQ_IRQ_EN
    ,
    output logic       irq
`endif
);

    localparam int unsigned TICK_P     = CPU_FREQ / TICK_HZ;
    localparam logic [31:0] PRESC_LAST = 32'(TICK_P - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_W_MOTOR, S_W_SPD0, S_W_SPD1, S_W_EN, S_RUN, S_W_STOP
    } state_t;

    state_t      state_q, state_d;

    // Command layout: {motor[25:22], speed0[21:15], speed1[14:8], duration[7:0]}
    logic [3:0]  motor_q;
    logic [6:0]  spd0_q, spd1_q;
    logic [7:0]  dur_q;
    logic [25:0] fifo_q [4];
    logic [1:0]  rd_ptr_q, wr_ptr_q;
    logic [2:0]  count_q;
    logic        ovf_q;
    logic [25:0] act_q;
    logic [7:0]  remain_q;
    logic [31:0] presc_q;
    logic [7:0]  dout_q;

    // Address decode relative to each register window (wraps harmlessly)
    logic [7:0]  seq_off, mc_off;
    logic        seq_hit, cpu_mc;
    logic        push_req, push_ok, push_drop, pop, abort, ovf_clr;
    logic        full, empty, busy;
    logic        seq_req;
    logic [2:0]  seq_reg;
    logic [7:0]  seq_data;
    logic [7:0]  rd_data;

    assign seq_off   = address - SEQ_ADDRESS;
    assign mc_off    = address - MC_ADDRESS;
    assign seq_hit   = (seq_off < 8'd6);
    assign cpu_mc    = (w_en | r_en) & (mc_off < 8'd6);

    assign full      = (count_q == 3'd4);
    assign empty     = (count_q == 3'd0);
    assign busy      = (state_q != S_IDLE);

    // Abort outranks a push in the same cycle; a pop frees a slot for a push
    assign abort     = w_en & seq_hit & (seq_off == 8'd4) & din[0];
    assign ovf_clr   = w_en & seq_hit & (seq_off == 8'd4) & din[7];
    assign push_req  = w_en & seq_hit & (seq_off == 8'd3) & ~abort;
    assign pop       = (state_q == S_LOAD) & ~abort;
    assign push_ok   = push_req & (~full | pop);
    assign push_drop = push_req & full & ~pop;

    // Next-state logic and sequencer write request for the motor port
    always_comb begin
        state_d  = state_q;
        seq_req  = 1'b0;
        seq_reg  = 3'd0;
        seq_data = 8'h00;
        case (state_q)
            S_IDLE:    if (!empty) state_d = S_LOAD;
            S_LOAD:    state_d = S_W_MOTOR;
            S_W_MOTOR: begin
                seq_req  = 1'b1;
                seq_reg  = 3'd0;
                seq_data = {4'h0, act_q[25:22]};
                if (!cpu_mc) state_d = S_W_SPD0;
            end
            S_W_SPD0:  begin
                seq_req  = 1'b1;
                seq_reg  = 3'd2;
                seq_data = {1'b0, act_q[21:15]};
                if (!cpu_mc) state_d = S_W_SPD1;
            end
            S_W_SPD1:  begin
                seq_req  = 1'b1;
                seq_reg  = 3'd3;
                seq_data = {1'b0, act_q[14:8]};
                if (!cpu_mc) state_d = S_W_EN;
            end
            S_W_EN:    begin
                seq_req  = 1'b1;
                seq_reg  = 3'd1;
                seq_data = 8'h01;
                if (!cpu_mc) state_d = S_RUN;
            end
            S_RUN:     if (remain_q == 8'd0) state_d = empty ? S_W_STOP : S_LOAD;
            S_W_STOP:  begin
                seq_req  = 1'b1;
                seq_reg  = 3'd1;
                seq_data = 8'h00;
                if (!cpu_mc) state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
        if (abort) state_d = S_W_STOP;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Motor port mux: a CPU access to the controller window always wins
    always_comb begin
        mc_address = 8'h00;
        mc_din     = 8'h00;
        mc_w_en    = 1'b0;
        mc_r_en    = 1'b0;
        if (cpu_mc) begin
            mc_address = address;
            mc_din     = din;
            mc_w_en    = w_en;
            mc_r_en    = r_en;
        end else if (seq_req) begin
            mc_address = MC_ADDRESS + {5'd0, seq_reg};
            mc_din     = seq_data;
            mc_w_en    = 1'b1;
        end
    end

    // Register read mux
    always_comb begin
        rd_data = 8'h00;
        if (seq_hit) begin
            case (seq_off[2:0])
                3'd3:    rd_data = dur_q;
                3'd4:    rd_data = {ovf_q, busy, full, empty, 1'b0, count_q};
                3'd5:    rd_data = remain_q;
                default: rd_data = 8'h00;
            endcase
        end
    end

    // Staging registers and registered read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            motor_q <= 4'h0;
            spd0_q  <= 7'h00;
            spd1_q  <= 7'h00;
            dur_q   <= 8'h00;
            dout_q  <= 8'h00;
        end else begin
            if (w_en && seq_hit && seq_off == 8'd0) motor_q <= din[3:0];
            if (w_en && seq_hit && seq_off == 8'd1) spd0_q  <= din[6:0];
            if (w_en && seq_hit && seq_off == 8'd2) spd1_q  <= din[6:0];
            if (w_en && seq_hit && seq_off == 8'd3) dur_q   <= din;
            if (r_en) dout_q <= rd_data;
        end
    end

    assign dout = dout_q;

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
        end else begin
            if (abort) begin
                rd_ptr_q <= 2'd0;
                wr_ptr_q <= 2'd0;
                count_q  <= 3'd0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
                if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
                case ({push_ok, pop})
                    2'b10:   count_q <= count_q + 3'd1;
                    2'b01:   count_q <= count_q - 3'd1;
                    default: count_q <= count_q;
                endcase
            end
            if (push_drop)    ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    // FIFO storage needs no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= {motor_q, spd0_q, spd1_q, din};
    end

    // Active command, remaining ticks and tick prescaler
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_q    <= 26'd0;
            remain_q <= 8'd0;
            presc_q  <= 32'd0;
        end else begin
            if (pop) act_q <= fifo_q[rd_ptr_q];
            if (abort) begin
                remain_q <= 8'd0;
                presc_q  <= 32'd0;
            end else if (state_q == S_W_EN && state_d == S_RUN) begin
                remain_q <= act_q[7:0];
                presc_q  <= 32'd0;
            end else if (state_q == S_RUN) begin
                if (presc_q == PRESC_LAST) begin
                    presc_q <= 32'd0;
                    if (remain_q != 8'd0) remain_q <= remain_q - 8'd1;
                end else begin
                    presc_q <= presc_q + 32'd1;
                end
            end
        end
    end

`ifdef MOTION_SEQ_IRQ_EN
    logic irq_q;

    // One-cycle pulse each time the motors have been stopped and we go idle
    always_ff @(posedge clk) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= (state_q == S_W_STOP) && (state_d == S_IDLE);
    end

    assign irq = irq_q;
`else
    // No interrupt output in this build
`endif

endmodule
`default_nettype wire
